// File: rtl/wb_regfile.sv
// Register file with a per-register pending-write scoreboard for an in-order pipeline.
// Decode issues writers (issue_en/issue_rd); the ME stage retires them (ME_wrReg/ME_rd).
// Operand reads stall while an older writer to that register is still outstanding.
// Optional macro WB_BYPASS_EN forwards ME_result to a read whose only pending writer
// is retiring this cycle; without it such a read stalls one more cycle.
module wb_regfile #(
  parameter int unsigned DBITS               = 32,
  parameter int unsigned REG_INDEX_BIT_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ME_wrReg,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] ME_rd,
  input  logic [DBITS-1:0]               ME_result,
  input  logic                           issue_en,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] issue_rd,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs1_idx,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs2_idx,
  input  logic                           rs1_used,
  input  logic                           rs2_used,
  output logic [DBITS-1:0]               rs1_data,
  output logic [DBITS-1:0]               rs2_data,
  output logic                           stall,
  output logic                           sb_err
);

  localparam int unsigned NREGS = 2 ** REG_INDEX_BIT_WIDTH;

  logic [DBITS-1:0] regs_q [NREGS];
  logic [DBITS-1:0] regs_d [NREGS];
  logic [1:0]       pend_q [NREGS];
  logic [1:0]       pend_d [NREGS];
  logic             sb_err_q, sb_err_d;

  logic byp1, byp2, haz1, haz2, sat;

  // Operand forwarding, hazard detection and stall; purely combinational.
  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
`ifdef WB_BYPASS_EN
    // Forward only when the retiring write is the last outstanding one.
    byp1 = ME_wrReg && (ME_rd == rs1_idx) && (pend_q[rs1_idx] == 2'd1);
    byp2 = ME_wrReg && (ME_rd == rs2_idx) && (pend_q[rs2_idx] == 2'd1);
`endif
    haz1  = (pend_q[rs1_idx] != 2'd0) && !byp1;
    haz2  = (pend_q[rs2_idx] != 2'd0) && !byp2;
    sat   = issue_en && (pend_q[issue_rd] == 2'd3);
    stall = reset && (sat || (rs1_used && haz1) || (rs2_used && haz2));

    rs1_data = '0;
    rs2_data = '0;
    if (reset) begin
      rs1_data = byp1 ? ME_result : regs_q[rs1_idx];
      rs2_data = byp2 ? ME_result : regs_q[rs2_idx];
    end
  end

  assign sb_err = sb_err_q;

  // Next-state for register contents, pending counters and the sticky underflow flag.
  always_comb begin
    regs_d   = regs_q;
    pend_d   = pend_q;
    sb_err_d = sb_err_q;
    if (ME_wrReg) begin
      regs_d[ME_rd] = ME_result;
    end
    for (int unsigned r = 0; r < NREGS; r++) begin
      logic inc, dec;
      inc = issue_en && !stall && (issue_rd == REG_INDEX_BIT_WIDTH'(r));
      dec = ME_wrReg && (ME_rd == REG_INDEX_BIT_WIDTH'(r));
      if (inc && !dec) begin
        pend_d[r] = pend_q[r] + 2'd1;
      end else if (dec && !inc) begin
        if (pend_q[r] == 2'd0) begin
          // Retire with nothing outstanding: keep at zero and flag it.
          sb_err_d = 1'b1;
        end else begin
          pend_d[r] = pend_q[r] - 2'd1;
        end
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q   <= '{default: '0};
      pend_q   <= '{default: '0};
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      pend_q   <= pend_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expectations follow WB_BYPASS_EN if defined.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        ME_wrReg;
  logic [3:0]  ME_rd;
  logic [31:0] ME_result;
  logic        issue_en;
  logic [3:0]  issue_rd;
  logic [3:0]  rs1_idx, rs2_idx;
  logic        rs1_used, rs2_used;
  logic [31:0] rs1_data, rs2_data;
  logic        stall, sb_err;

  int n_cmp = 0;
  int n_mis = 0;

  wb_regfile #(.DBITS(32), .REG_INDEX_BIT_WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ME_wrReg  (ME_wrReg),
    .ME_rd     (ME_rd),
    .ME_result (ME_result),
    .issue_en  (issue_en),
    .issue_rd  (issue_rd),
    .rs1_idx   (rs1_idx),
    .rs2_idx   (rs2_idx),
    .rs1_used  (rs1_used),
    .rs2_used  (rs2_used),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .stall     (stall),
    .sb_err    (sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; ME_wrReg = 1'b0; ME_rd = '0; ME_result = '0;
    issue_en = 1'b0; issue_rd = '0; rs1_idx = 4'd5; rs2_idx = '0;
    rs1_used = 1'b1; rs2_used = 1'b0;
    #2;
    chk("in_reset_rs1", rs1_data, 32'h0);
    chk("in_reset_stall", {31'b0, stall}, 32'h0);
    #10 reset = 1'b1;

    // Post-reset read of r5
    next(); #1;
    chk("r5_data", rs1_data, 32'h0);
    chk("r5_stall", {31'b0, stall}, 32'h0);
    chk("r5_sberr", {31'b0, sb_err}, 32'h0);

    // RAW hazard on r3, resolved by writeback
    rs1_used = 1'b0; issue_en = 1'b1; issue_rd = 4'd3; #1;
    chk("iss3_stall", {31'b0, stall}, 32'h0);
    next(); issue_en = 1'b0; rs1_idx = 4'd3; rs1_used = 1'b1; #1;
    chk("raw3_stall", {31'b0, stall}, 32'h1);
    next(); ME_wrReg = 1'b1; ME_rd = 4'd3; ME_result = 32'hDEADBEEF; #1;
`ifdef WB_BYPASS_EN
    chk("wb3_stall", {31'b0, stall}, 32'h0);
    chk("wb3_data", rs1_data, 32'hDEADBEEF);
`else
    chk("wb3_stall", {31'b0, stall}, 32'h1);
    chk("wb3_data", rs1_data, 32'h0);
`endif
    next(); ME_wrReg = 1'b0; #1;
    chk("post3_stall", {31'b0, stall}, 32'h0);
    chk("post3_data", rs1_data, 32'hDEADBEEF);

    // Saturation of pending[7]
    rs1_used = 1'b0; issue_en = 1'b1; issue_rd = 4'd7;
    for (int i = 0; i < 3; i++) begin
      #1 chk("iss7_stall", {31'b0, stall}, 32'h0);
      next();
    end
    #1 chk("sat7_stall", {31'b0, stall}, 32'h1);
    next(); #1 chk("sat7_hold", {31'b0, stall}, 32'h1);
    next(); ME_wrReg = 1'b1; ME_rd = 4'd7; ME_result = 32'h0000_0777; #1;
    chk("sat7_wb_stall", {31'b0, stall}, 32'h1);
    next(); ME_wrReg = 1'b0; #1;
    chk("iss7_accept", {31'b0, stall}, 32'h0);
    next(); #1;
    chk("sat7_again", {31'b0, stall}, 32'h1);
    issue_en = 1'b0;

    // Simultaneous issue and retire on r2 leaves the count unchanged
    next(); issue_en = 1'b1; issue_rd = 4'd2; #1;
    next(); ME_wrReg = 1'b1; ME_rd = 4'd2; ME_result = 32'h0000_1234; #1;
    chk("iss_wb2_stall", {31'b0, stall}, 32'h0);
    next(); issue_en = 1'b0; ME_wrReg = 1'b0;
    rs2_idx = 4'd2; rs2_used = 1'b1; rs1_idx = 4'd2; #1;
    chk("raw2_stall", {31'b0, stall}, 32'h1);
    chk("raw2_data", rs2_data, 32'h0000_1234);
    chk("same_idx_data", rs1_data, rs2_data);
    rs1_used = 1'b1; ME_wrReg = 1'b1; ME_rd = 4'd2; ME_result = 32'h0000_5678; #1;
`ifdef WB_BYPASS_EN
    chk("byp2_stall", {31'b0, stall}, 32'h0);
    chk("byp2_rs2", rs2_data, 32'h0000_5678);
    chk("byp2_rs1", rs1_data, 32'h0000_5678);
`else
    chk("byp2_stall", {31'b0, stall}, 32'h1);
    chk("byp2_rs2", rs2_data, 32'h0000_1234);
    chk("byp2_rs1", rs1_data, 32'h0000_1234);
`endif
    next(); ME_wrReg = 1'b0; #1;
    chk("drain2_stall", {31'b0, stall}, 32'h0);
    chk("no_err_yet", {31'b0, sb_err}, 32'h0);

    // Underflow on r9
    rs1_used = 1'b0; rs2_used = 1'b0;
    ME_wrReg = 1'b1; ME_rd = 4'd9; ME_result = 32'hA5A5_0009; #1;
    chk("pre_uf_err", {31'b0, sb_err}, 32'h0);
    next(); ME_wrReg = 1'b0; rs1_idx = 4'd9; rs1_used = 1'b1; #1;
    chk("uf_data", rs1_data, 32'hA5A5_0009);
    chk("uf_err", {31'b0, sb_err}, 32'h1);
    chk("uf_stall", {31'b0, stall}, 32'h0);
    next(); next(); #1;
    chk("uf_sticky", {31'b0, sb_err}, 32'h1);

    // Mid-cycle asynchronous reset with r4 pending
    issue_en = 1'b1; issue_rd = 4'd4; rs1_used = 1'b0;
    next(); issue_en = 1'b0; rs1_idx = 4'd4; rs1_used = 1'b1; #1;
    chk("raw4_stall", {31'b0, stall}, 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_r4", rs1_data, 32'h0);
    chk("rst_err", {31'b0, sb_err}, 32'h0);
    rs2_idx = 4'd9; rs2_used = 1'b1; issue_en = 1'b1; issue_rd = 4'd7; #1;
    chk("rst_r9", rs2_data, 32'h0);
    chk("rst_sat7", {31'b0, stall}, 32'h0);
    next(); #1 reset = 1'b1;
    issue_en = 1'b0; rs2_used = 1'b0;
    #1 chk("rel_stall", {31'b0, stall}, 32'h0);
    ME_wrReg = 1'b1; ME_rd = 4'd3; ME_result = 32'h1; #1;
    chk("rel_err_pre", {31'b0, sb_err}, 32'h0);
    next(); ME_wrReg = 1'b0; #1;
    chk("rel_err_post", {31'b0, sb_err}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DBITS, default 32, data width.
REQ-002 SHALL have parameter REG_INDEX_BIT_WIDTH, default 4, register index width; NREGS = 2**REG_INDEX_BIT_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ME_wrReg  input  1  writeback request from ME stage register.
REQ-006 SHALL have port ME_rd  input  REG_INDEX_BIT_WIDTH  writeback destination index.
REQ-007 SHALL have port ME_result  input  DBITS  writeback data.
REQ-008 SHALL have port issue_en  input  1  decode issues an instruction that will write issue_rd.
REQ-009 SHALL have port issue_rd  input  REG_INDEX_BIT_WIDTH  destination of issued instruction.
REQ-010 SHALL have ports rs1_idx, rs2_idx  input  REG_INDEX_BIT_WIDTH  read indices; rs1_used, rs2_used  input  1  operand needed.
REQ-011 SHALL have ports rs1_data, rs2_data  output  DBITS  combinational read data.
REQ-012 SHALL have port stall  output  1  decode must hold; issue_en is ignored while stall=1.
REQ-013 SHALL have port sb_err  output  1  sticky scoreboard-underflow flag.

Function
REQ-014 SHALL hold NREGS x DBITS registers; write of ME_result to reg[ME_rd] on rising clk when ME_wrReg=1.
REQ-015 SHALL read asynchronously: rsN_data = reg[rsN_idx], subject to REQ-021.
REQ-016 SHALL keep a 2-bit pending counter per register (scoreboard), range 0..3.
REQ-017 Per cycle, for register r: inc = issue_en & !stall & issue_rd==r; dec = ME_wrReg & ME_rd==r; inc&dec -> unchanged; inc only -> +1; dec only -> -1.
REQ-018 dec with counter 0 SHALL leave counter at 0 and set sb_err=1 until reset.
REQ-019 stall SHALL assert when issue_en=1 and pending[issue_rd]==3 (saturation), independent of operand hazards.
REQ-020 stall SHALL assert when (rs1_used & hazard(rs1_idx)) | (rs2_used & hazard(rs2_idx)); hazard(i) = pending[i]!=0 and not bypass_hit(i).
REQ-021 bypass_hit(i) = ME_wrReg & ME_rd==i & pending[i]==1; when true, rsN_data SHALL equal ME_result same cycle.
REQ-022 rs1_idx==rs2_idx SHALL return identical data and identical hazard evaluation for both ports.
REQ-023 An instruction SHALL NOT read its own issue_rd as pending in the same cycle (counter update is registered).
REQ-024 stall SHALL be purely combinational from current inputs and counters; no added latency.

Reset
REQ-025 reset=0 SHALL asynchronously clear all registers to 0, all pending counters to 0, sb_err to 0.
REQ-026 During reset rs1_data, rs2_data SHALL read 0 and stall SHALL be 0.
REQ-027 Release of reset mid-operation SHALL discard all in-flight scoreboard state; first post-reset writeback to a zero counter sets sb_err.

Configuration
REQ-028 Macro WB_BYPASS_EN SHALL select write-through forwarding.
REQ-029 With WB_BYPASS_EN defined, REQ-021 applies.
REQ-030 Without WB_BYPASS_EN, bypass_hit SHALL be constant 0: any pending[i]!=0 on a used operand stalls and rsN_data always returns stored value.

Verification
REQ-031 Reset then read r5 -> rs1_data=0, stall=0, sb_err=0.
REQ-032 issue_rd=3 issue_en=1; next cycle rs1_idx=3 rs1_used=1 -> stall=1; cycle ME_wrReg=1 ME_rd=3 ME_result=0xDEADBEEF -> with WB_BYPASS_EN stall=0 and rs1_data=0xDEADBEEF same cycle; without it stall=1 that cycle, 0 next cycle with rs1_data=0xDEADBEEF.
REQ-033 Three issues to r7, fourth issue_en to r7 -> stall=1, pending[7] stays 3; one writeback to r7 -> fourth issue accepted next cycle.
REQ-034 Same cycle issue_rd=2 and ME_wrReg ME_rd=2 with pending[2]=1 -> pending[2] stays 1; rs2_idx=2 rs2_used=1 next cycle -> stall=1.
REQ-035 ME_wrReg=1 ME_rd=9 with pending[9]=0 -> reg[9] written, sb_err=1 and stays 1 until reset=0.
REQ-036 Issue r4, assert reset=0 asynchronously mid-cycle -> pending[4]=0, reg[4]=0, stall=0 immediately.
